clint_timer: RTL and testbench

- Machine-mode core-local interruptor; a Wishbone B4 classic slave on the system bus, downstream of the core's data master port.
- Holds the 64-bit mtime/mtimecmp pair and the msip software-interrupt bit.
- Drives the core's xint_mtip_i and xint_msip_i inputs directly.
- One instance per hart.

---
 rtl/clint_timer.sv | 199 +++++++++++++++++++
 tb/tb_clint_timer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: machine-mode core-local interruptor for one hart.
//
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare value and the
// msip software-interrupt bit. It sits behind a Wishbone B4 classic slave port
// and drives the core's timer and software interrupt inputs directly.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   wbs_addr_i   byte address; bits [31:16] select the region, [15:0] the register
//   wbs_dat_i    write data
//   wbs_sel_i    byte enables for writes
//   wbs_we_i     write enable
//   wbs_cyc_i    bus cycle
//   wbs_stb_i    strobe
//   wbs_dat_o    read data, valid with wbs_ack_o, 0 otherwise
//   wbs_ack_o    transfer acknowledge
//   wbs_err_o    error for unmapped or misaligned accesses
//   xint_mtip_o  machine timer interrupt pending (mtime >= mtimecmp)
//   xint_msip_o  machine software interrupt pending (copy of msip)
//
// Register map (offset = wbs_addr_i[15:0]):
//   0x0000 msip (bit 0 only), 0x4000/0x4004 mtimecmp lo/hi,
//   0xBFF8/0xBFFC mtime lo/hi.
//
// Build option: define CLINT_PRESCALER_EN to make mtime advance once every
// PRESCALE clock cycles instead of every cycle.
//
// Handshake: a request is seen in any cycle where cyc & stb are high and no
// response is currently being driven. Exactly one of ack/err is raised for one
// cycle in the following cycle. Because the response itself masks the request,
// a strobe held high is answered every other cycle.

module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  localparam logic [15:0] OFS_MSIP   = 16'h0000;
  localparam logic [15:0] OFS_CMP_LO = 16'h4000;
  localparam logic [15:0] OFS_CMP_HI = 16'h4004;
  localparam logic [15:0] OFS_MT_LO  = 16'hBFF8;
  localparam logic [15:0] OFS_MT_HI  = 16'hBFFC;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic        req;
  logic [15:0] offset;
  logic        region_hit;
  logic        aligned;
  logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mt_lo, hit_mt_hi;
  logic        addr_ok;
  logic        wr_en;

  assign req        = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign offset     = wbs_addr_i[15:0];
  assign region_hit = (wbs_addr_i[31:16] == BASE_ADDR[31:16]);
  assign aligned    = (wbs_addr_i[1:0] == 2'b00);

  assign hit_msip   = (offset == OFS_MSIP);
  assign hit_cmp_lo = (offset == OFS_CMP_LO);
  assign hit_cmp_hi = (offset == OFS_CMP_HI);
  assign hit_mt_lo  = (offset == OFS_MT_LO);
  assign hit_mt_hi  = (offset == OFS_MT_HI);

  assign addr_ok = region_hit & aligned &
                   (hit_msip | hit_cmp_lo | hit_cmp_hi | hit_mt_lo | hit_mt_hi);
  assign wr_en   = req & wbs_we_i & addr_ok;

  // Byte-lane merge: each enabled lane takes the new byte, others keep the old.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Read mux (values as they stand during the request cycle)
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'h0;
    if (hit_msip)   rdata = {31'h0, msip};
    if (hit_cmp_lo) rdata = mtimecmp[31:0];
    if (hit_cmp_hi) rdata = mtimecmp[63:32];
    if (hit_mt_lo)  rdata = mtime[31:0];
    if (hit_mt_hi)  rdata = mtime[63:32];
  end

  // ---------------------------------------------------------------------------
  // mtime tick enable
  // ---------------------------------------------------------------------------
  logic tick;

`ifdef CLINT_PRESCALER_EN
  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

  logic [15:0] tick_cnt;

  // Free-running divider; mtime writes deliberately do not restart it.
  assign tick = (tick_cnt == PRESCALE_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_cnt <= 16'h0;
    end else if (tick) begin
      tick_cnt <= 16'h0;
    end else begin
      tick_cnt <= tick_cnt + 16'h1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Bus response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= req & addr_ok;
      wbs_err_o <= req & ~addr_ok;
      wbs_dat_o <= (req & addr_ok & ~wbs_we_i) ? rdata : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      msip     <= 1'b0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      if (wr_en && hit_msip && wbs_sel_i[0]) msip <= wbs_dat_i[0];
      if (wr_en && hit_cmp_lo)
        mtimecmp[31:0]  <= byte_merge(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
      if (wr_en && hit_cmp_hi)
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
    end
  end

  // A write to either mtime word wins over the increment for that cycle: the
  // other word holds, and no carry is propagated.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime <= 64'h0;
    end else if (wr_en && hit_mt_lo) begin
      mtime[31:0]  <= byte_merge(mtime[31:0], wbs_dat_i, wbs_sel_i);
    end else if (wr_en && hit_mt_hi) begin
      mtime[63:32] <= byte_merge(mtime[63:32], wbs_dat_i, wbs_sel_i);
    end else if (tick) begin
      mtime <= mtime + 64'h1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt outputs (registered, one cycle behind the registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xint_mtip_o <= 1'b0;
      xint_msip_o <= 1'b0;
    end else begin
      xint_mtip_o <= (mtime >= mtimecmp);
      xint_msip_o <= msip;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Testbench for clint_timer: directed and randomized bus accesses checked
// against a reference model that derives mtime from elapsed cycles.

module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_err_o;
  logic        xint_mtip_o;
  logic        xint_msip_o;

  clint_timer #(
    .BASE_ADDR(32'h0200_0000),
    .PRESCALE (P)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wbs_addr_i (wbs_addr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o),
    .xint_mtip_o(xint_mtip_o),
    .xint_msip_o(xint_msip_o)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter
  // ---------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model. mtime is "value at anchor cycle + ticks elapsed", ticks
  // counted from the cycle reset was released. A one-deep history lets the
  // model answer for the cycle just before the latest write.
  // ---------------------------------------------------------------------------
  int          r_cyc;
  int          a_cyc, pa_cyc;
  logic [63:0] a_val, pa_val;
  logic [63:0] cmp_m, cmp_p;
  int          cmp_c;
  logic        msip_m, msip_p;
  int          msip_c;

  function automatic logic [63:0] incs(input int from_c, input int to_c);
    return 64'((to_c - r_cyc) / P - (from_c - r_cyc) / P);
  endfunction

  function automatic logic [63:0] mt_at(input int c);
    if (c >= a_cyc) return a_val + incs(a_cyc, c);
    return pa_val + incs(pa_cyc, c);
  endfunction

  function automatic logic [63:0] cmp_at(input int c);
    return (c >= cmp_c) ? cmp_m : cmp_p;
  endfunction

  function automatic logic msip_at(input int c);
    return (c >= msip_c) ? msip_m : msip_p;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic addr_ok(input logic [31:0] a);
    logic [15:0] o;
    o = a[15:0];
    return (a[31:16] == 16'h0200) &&
           (o == 16'h0000 || o == 16'h4000 || o == 16'h4004 ||
            o == 16'hBFF8 || o == 16'hBFFC);
  endfunction

  function automatic logic [31:0] reg_val(input logic [15:0] o, input int c);
    logic [63:0] v;
    case (o)
      16'h0000: v = {63'h0, msip_at(c)};
      16'h4000: v = cmp_at(c);
      16'h4004: begin v = cmp_at(c); v = v >> 32; end
      16'hBFF8: v = mt_at(c);
      16'hBFFC: begin v = mt_at(c); v = v >> 32; end
      default:  v = 64'h0;
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    r_cyc  = cyc;
    a_cyc  = cyc;  pa_cyc = cyc;
    a_val  = 64'h0; pa_val = 64'h0;
    cmp_m  = '1; cmp_p = '1; cmp_c = cyc;
    msip_m = 1'b0; msip_p = 1'b0; msip_c = cyc;
  endtask

  // Apply a write whose request cycle was rc; it lands at the end of rc.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int rc);
    logic [63:0] v;
    if (!addr_ok(a)) return;
    case (a[15:0])
      16'h0000: begin
        msip_p = msip_m; msip_c = rc + 1;
        if (s[0]) msip_m = d[0];
      end
      16'h4000: begin
        cmp_p = cmp_m; cmp_c = rc + 1;
        cmp_m[31:0] = merge(cmp_m[31:0], d, s);
      end
      16'h4004: begin
        cmp_p = cmp_m; cmp_c = rc + 1;
        cmp_m[63:32] = merge(cmp_m[63:32], d, s);
      end
      16'hBFF8: begin
        v = mt_at(rc);
        pa_val = a_val; pa_cyc = a_cyc;
        a_val = {v[63:32], merge(v[31:0], d, s)}; a_cyc = rc + 1;
      end
      16'hBFFC: begin
        v = mt_at(rc);
        pa_val = a_val; pa_cyc = a_cyc;
        a_val = {merge(v[63:32], d, s), v[31:0]}; a_cyc = rc + 1;
      end
      default: ;
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Interrupt outputs seen in the current cycle reflect the previous cycle.
  task automatic chk_irq();
    int          c;
    logic [63:0] m, k;
    logic        em, es;
    c = cyc - 1;
    if (c < r_cyc) begin
      em = 1'b0; es = 1'b0;
    end else begin
      m = mt_at(c); k = cmp_at(c);
      em = (m >= k);
      es = msip_at(c);
    end
    chk("mtip", 64'(xint_mtip_o), 64'(em));
    chk("msip", 64'(xint_msip_o), 64'(es));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk_irq();
    end
  endtask

  task automatic bus_idle();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_addr_i = 32'h0; wbs_dat_i = 32'h0;
  endtask

  // Single access, called at a negedge with the bus idle. Request cycle is
  // the current one; the response is checked in the next cycle and the
  // return to idle in the one after.
  task automatic wb(input logic [31:0] a, input logic we, input logic [3:0] s,
                    input logic [31:0] d);
    int          rc;
    logic        ok;
    logic [31:0] ed;
    rc = cyc;
    ok = addr_ok(a);
    ed = (ok && !we) ? reg_val(a[15:0], rc) : 32'h0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = s; wbs_addr_i = a; wbs_dat_i = d;
    @(negedge clk_i);
    chk("ack", 64'(wbs_ack_o), 64'(ok));
    chk("err", 64'(wbs_err_o), 64'(!ok));
    chk("rdata", 64'(wbs_dat_o), 64'(ed));
    bus_idle();
    if (we) model_write(a, d, s, rc);
    chk_irq();
    @(negedge clk_i);
    chk("ack_drop", 64'(wbs_ack_o), 64'h0);
    chk("err_drop", 64'(wbs_err_o), 64'h0);
    chk("dat_zero", 64'(wbs_dat_o), 64'h0);
    chk_irq();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          c0, rise, rc;
    logic [31:0] d, ad;
    logic [63:0] v;
    logic [3:0]  s;

    bus_idle();
    rst_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_ack", 64'(wbs_ack_o), 64'h0);
    chk("rst_err", 64'(wbs_err_o), 64'h0);
    chk("rst_dat", 64'(wbs_dat_o), 64'h0);
    chk("rst_mtip", 64'(xint_mtip_o), 64'h0);
    chk("rst_msip", 64'(xint_msip_o), 64'h0);
    rst_i = 1'b0;
    model_reset();

    // mtime read right after reset and again 10 cycles later
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    idle(10);
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_BFFC, 1'b0, 4'hF, 32'h0);

    // mtimecmp = 0x40: mtip rises one cycle after mtime first equals 0x40
    wb(32'h0200_4004, 1'b1, 4'hF, 32'h0);
    wb(32'h0200_4000, 1'b1, 4'hF, 32'h40);
    c0 = -1;
    for (int c = cyc; c < cyc + 2000; c++) begin
      v = mt_at(c);
      if (v == 64'h40) begin c0 = c; break; end
    end
    rise = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      chk_irq();
      if (xint_mtip_o === 1'b1 && rise < 0) rise = cyc;
      if (cyc >= c0 + 3) break;
    end
    chk("mtip_rise", 64'(rise), 64'(c0 + 1));
    wb(32'h0200_4000, 1'b1, 4'hF, 32'hFFFF_FFFF);   // clears mtip after landing
    idle(2);
    wb(32'h0200_4004, 1'b1, 4'hF, 32'hFFFF_FFFF);
    idle(2);

    // carry from low into high word
    wb(32'h0200_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFE);
    wb(32'h0200_BFFC, 1'b1, 4'hF, 32'h0);
    idle(2 * P);
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_BFFC, 1'b0, 4'hF, 32'h0);

    // 64-bit wrap with mtimecmp at all-ones
    wb(32'h0200_BFFC, 1'b1, 4'hF, 32'hFFFF_FFFF);
    wb(32'h0200_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFF);
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_BFFC, 1'b0, 4'hF, 32'h0);
    idle(2 * P + 2);

    // msip: byte-0 write, read back, sel=0 no-op write
    wb(32'h0200_0000, 1'b1, 4'b0001, 32'hFFFF_FFFF);
    wb(32'h0200_0000, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_0000, 1'b1, 4'b0000, 32'h0);
    wb(32'h0200_0000, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_0000, 1'b1, 4'b1110, 32'h0);   // bit 0 lane not selected
    wb(32'h0200_0000, 1'b0, 4'hF, 32'h0);

    // error responses with no state change
    wb(32'h0200_0008, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_4002, 1'b1, 4'hF, 32'h1234_5678);
    wb(32'h0300_0000, 1'b1, 4'hF, 32'h0);
    wb(32'h0300_4000, 1'b1, 4'hF, 32'h0);
    wb(32'h0200_0001, 1'b1, 4'hF, 32'h0);
    wb(32'h0200_0000, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_4000, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_4004, 1'b0, 4'hF, 32'h0);

    // held strobe on an unmapped address: err every other cycle
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_addr_i = 32'h0200_0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("held_err", 64'(wbs_err_o), 64'(i % 2 == 0));
      chk("held_err_ack", 64'(wbs_ack_o), 64'h0);
    end
    bus_idle();
    idle(1);

    // held strobe read of mtime lo: ack every other cycle, fresh data each time
    rc = cyc;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_addr_i = 32'h0200_BFF8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("held_ack", 64'(wbs_ack_o), 64'(i % 2 == 0));
      d = (i % 2 == 0) ? reg_val(16'hBFF8, rc + i) : 32'h0;
      chk("held_dat", 64'(wbs_dat_o), 64'(d));
    end
    bus_idle();
    idle(1);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 6))
        0: begin
          v = mt_at(cyc);
          wb(32'h0200_4000, 1'b1, s, v[31:0] + 32'($urandom_range(0, 12)));
        end
        1: begin
          v = mt_at(cyc);
          wb(32'h0200_4004, 1'b1, 4'hF, v[63:32] + 32'($urandom_range(0, 1)));
        end
        2: begin
          case ($urandom_range(0, 4))
            0: ad = 32'h0200_0000;
            1: ad = 32'h0200_4000;
            2: ad = 32'h0200_4004;
            3: ad = 32'h0200_BFF8;
            default: ad = 32'h0200_BFFC;
          endcase
          wb(ad, 1'b0, 4'hF, 32'h0);
        end
        3: wb(32'h0200_0000, 1'b1, s, $urandom);
        4: wb(32'h0200_BFF8, 1'b1, s, $urandom);
        5: begin
          ad = {16'h0200, 16'($urandom)};
          if ($urandom_range(0, 1) == 1) ad[31:16] = 16'($urandom_range(0, 16'h01FF));
          wb(ad, 1'($urandom_range(0, 1)), s, $urandom);
        end
        default: idle($urandom_range(0, 5));
      endcase
    end

    // mtime rate over 100 cycles
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    idle(100);
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);

    // reset asserted in the request cycle of a read: no response, state reset
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_addr_i = 32'h0200_BFF8;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_ack", 64'(wbs_ack_o), 64'h0);
    chk("rst_mid_dat", 64'(wbs_dat_o), 64'h0);
    bus_idle();
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    chk("rst_mid_mtip", 64'(xint_mtip_o), 64'h0);
    chk("rst_mid_msip", 64'(xint_msip_o), 64'h0);
    wb(32'h0200_BFF8, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_BFFC, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_4000, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_4004, 1'b0, 4'hF, 32'h0);
    wb(32'h0200_0000, 1'b0, 4'hF, 32'h0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
